// File: rtl/mem_pkg.sv
// Shared types and constants for the memory arbiter slice.
// Optional feature macro (see mem_arbiter): ARB_ROUND_ROBIN_EN.
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    localparam logic [7:0] LANE_B = 8'h01;
    localparam logic [7:0] LANE_H = 8'h03;
    localparam logic [7:0] LANE_W = 8'h0F;
    localparam logic [7:0] LANE_D = 8'hFF;

    function automatic logic is_misaligned(input logic [2:0] off, input size_t size);
        case (size)
            SZ_B:    is_misaligned = 1'b0;
            SZ_H:    is_misaligned = off[0];
            SZ_W:    is_misaligned = |off[1:0];
            default: is_misaligned = |off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment: store mask/data shift and load extract/extend.
// Purely combinational; store side uses live request, load side uses registered fields.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_off,
    input  size_t       st_size,
    input  logic [63:0] st_wdata,
    output logic [7:0]  st_mask,
    output logic [63:0] st_wdata_sh,
    input  logic [2:0]  ld_off,
    input  size_t       ld_size,
    input  logic        ld_signed,
    input  logic [63:0] ld_rdata,
    output logic [63:0] ld_data
);

    logic [7:0]  w_base;
    logic [63:0] w_ld_sh;

    always_comb begin
        case (st_size)
            SZ_B:    w_base = LANE_B;
            SZ_H:    w_base = LANE_H;
            SZ_W:    w_base = LANE_W;
            default: w_base = LANE_D;
        endcase
        st_mask     = w_base << st_off;
        st_wdata_sh = st_wdata << {st_off, 3'b000};
    end

    always_comb begin
        w_ld_sh = ld_rdata >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = {{56{ld_signed & w_ld_sh[7]}},  w_ld_sh[7:0]};
            SZ_H:    ld_data = {{48{ld_signed & w_ld_sh[15]}}, w_ld_sh[15:0]};
            SZ_W:    ld_data = {{32{ld_signed & w_ld_sh[31]}}, w_ld_sh[31:0]};
            default: ld_data = w_ld_sh;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instruction/data) arbiter onto a single-port RAM, one access per two cycles.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed data priority.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_wen,
    input  logic [1:0]        d_size,
    input  logic              d_signed,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              ram_en,
    output logic [7:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [ADDR_W-1:0] ADDR_LO_MASK = ADDR_W'(7);

    state_t      r_state;
    logic [2:0]  r_off;
    size_t       r_size;
    logic        r_signed;
    logic        r_wen;
    logic        r_misal;
    logic        r_i_rvalid;
    logic        r_d_rvalid;
    logic        r_d_err;

    logic        w_idle;
    logic        w_d_prio;
    logic        w_grant_d;
    logic        w_grant_i;
    logic        w_misal;
    logic [7:0]  w_mask;
    logic [63:0] w_wdata_sh;
    logic [63:0] w_ld_data;
    logic [ADDR_W-1:0] w_addr;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_i;
    assign w_d_prio = r_last_i;
`else
    assign w_d_prio = 1'b1;
`endif

    assign w_idle    = (r_state == ST_IDLE) && !rst;
    assign w_grant_d = w_idle && d_valid && (!i_valid || w_d_prio);
    assign w_grant_i = w_idle && i_valid && !w_grant_d;
    assign w_misal   = is_misaligned(d_addr[2:0], size_t'(d_size));
    assign w_addr    = w_grant_d ? d_addr : i_addr;

    assign i_ready   = w_grant_i;
    assign d_ready   = w_grant_d;
    assign ram_en    = w_grant_i || (w_grant_d && !w_misal);
    assign ram_addr  = w_addr & ~ADDR_LO_MASK;
    assign ram_we    = (w_grant_d && d_wen && !w_misal) ? w_mask : '0;
    assign ram_wdata = w_grant_d ? w_wdata_sh : '0;

    mem_lane_align u_align (
        .st_off      (d_addr[2:0]),
        .st_size     (size_t'(d_size)),
        .st_wdata    (d_wdata),
        .st_mask     (w_mask),
        .st_wdata_sh (w_wdata_sh),
        .ld_off      (r_off),
        .ld_size     (r_size),
        .ld_signed   (r_signed),
        .ld_rdata    (ram_rdata),
        .ld_data     (w_ld_data)
    );

    assign i_rvalid = r_i_rvalid;
    assign d_rvalid = r_d_rvalid;
    assign d_err    = r_d_err;
    assign i_rdata  = r_i_rvalid ? ram_rdata : '0;
    assign d_rdata  = (r_d_rvalid && !r_wen && !r_misal) ? w_ld_data : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_off      <= '0;
            r_size     <= SZ_B;
            r_signed   <= 1'b0;
            r_wen      <= 1'b0;
            r_misal    <= 1'b0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_i   <= 1'b1;
`endif
        end else begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_err    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state    <= ST_RESP_D;
                        r_d_rvalid <= 1'b1;
                        r_d_err    <= w_misal;
                        r_off      <= d_addr[2:0];
                        r_size     <= size_t'(d_size);
                        r_signed   <= d_signed;
                        r_wen      <= d_wen;
                        r_misal    <= w_misal;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_i   <= 1'b0;
`endif
                    end else if (w_grant_i) begin
                        r_state    <= ST_RESP_I;
                        r_i_rvalid <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_i   <= 1'b1;
`endif
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 64, fixed 64-bit doubleword path.
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports i_valid in 1, i_ready out 1, i_addr in ADDR_W: instruction read request.
REQ-006 SHALL have ports i_rvalid out 1, i_rdata out 64: instruction response.
REQ-007 SHALL have ports d_valid in 1, d_ready out 1, d_addr in ADDR_W, d_wen in 1, d_size in 2 (0=B,1=H,2=W,3=D), d_signed in 1, d_wdata in 64 (LSB-aligned): data request.
REQ-008 SHALL have ports d_rvalid out 1, d_rdata out 64, d_err out 1: data response.
REQ-009 SHALL have ports ram_en out 1, ram_we out 8, ram_addr out ADDR_W, ram_wdata out 64, ram_rdata in 64: downstream single-port memory; ram_rdata is valid the cycle after ram_en.

Function
REQ-010 SHALL implement FSM states IDLE, RESP_I, RESP_D.
REQ-011 In IDLE, a request SHALL be granted by asserting its ready combinationally; a transfer occurs when valid&ready.
REQ-012 In RESP_I/RESP_D both readies SHALL be 0; one access per two cycles maximum.
REQ-013 On grant, ram_en=1 the same cycle with ram_addr = request address with bits [2:0] cleared; FSM moves to RESP_I or RESP_D.
REQ-014 Store lane mask SHALL be (1,3,0xF,0xFF per size) << addr[2:0]; ram_wdata = d_wdata << 8*addr[2:0]; loads and instruction reads drive ram_we=0.
REQ-015 Misaligned data access (addr[2:0] not a multiple of 2^size) SHALL NOT assert ram_en; FSM still enters RESP_D.
REQ-016 In RESP_I, i_rvalid=1 for exactly one cycle with i_rdata=ram_rdata; FSM returns to IDLE.
REQ-017 In RESP_D, d_rvalid=1 for one cycle; loads: d_rdata = (ram_rdata >> 8*offset) truncated to size, sign-extended if d_signed else zero-extended; stores: d_rdata=0; misaligned: d_err=1, d_rdata=0, else d_err=0.
REQ-018 Responses SHALL have no backpressure; requester must accept.
REQ-019 Offset, size, signed and misaligned flag SHALL be registered at grant; requester need not hold inputs after handshake.
REQ-020 Simultaneous i_valid and d_valid in IDLE SHALL be resolved per REQ-030/031; the loser is granted in the next IDLE cycle if still valid.
REQ-021 Outputs i_rdata/d_rdata SHALL be 0 outside their rvalid cycle.

Reset
REQ-022 Reset SHALL force state IDLE, all registered flags 0, i_rvalid=d_rvalid=d_err=0 asynchronously.
REQ-023 While rst=1, ram_en, ram_we, i_ready, d_ready SHALL be 0.
REQ-024 Reset mid-access SHALL drop the pending response; no rvalid is produced for it after reset release.
REQ-025 First grant possible in the first cycle after rst deasserts.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined: on contention the port not granted most recently wins; last-grant flag resets to instruction (data wins first contention).
REQ-031 Without ARB_ROUND_ROBIN_EN: data port always wins contention (fixed priority); instruction starvation permitted.

Structure
REQ-032 Shared package mem_pkg SHALL hold state enum, size encodings, and lane-mask constants.
REQ-033 Lane shift, mask and load extension SHALL live in combinational sub-module mem_lane_align; FSM and arbitration in mem_arbiter.

Verification
REQ-040 Reset mid RESP_D: d load granted, rst pulsed next cycle -> d_rvalid never asserts, state IDLE, ram_en=0 during rst.
REQ-041 i_addr=0x80000008, ram_rdata=0x1122334455667788 -> ram_en=1, ram_addr=0x80000008 grant cycle; i_rvalid=1, i_rdata=0x1122334455667788 next cycle.
REQ-042 Store SH d_addr=0x80000006, d_wdata=0xABCD -> ram_we=0xC0, ram_wdata=0xABCD000000000000; d_rvalid=1, d_err=0 next cycle.
REQ-043 Load LB signed d_addr=0x80000003, ram_rdata=0x0000000080000000 -> d_rdata=0xFFFFFFFFFFFFFF80; unsigned -> 0x80.
REQ-044 LW d_addr=0x80000002 -> ram_en stays 0; d_rvalid=1, d_err=1, d_rdata=0.
REQ-045 i_valid and d_valid held 6 cycles -> fixed build: D,D,D grants; ARB_ROUND_ROBIN_EN build: D,I,D alternating.
